// File: rtl/k16_panel_mux.sv
// Panel-side end of the K16 front-panel nibble link: reassembles LED frames with
// tear-free commit, debounces the panel switches and serves them back per nibble address.
module k16_panel_mux #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned LINK_TIMEOUT    = 2500000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        io_clk,
  input  logic [2:0]  io_addr,
  input  logic [3:0]  io_leds,
  output logic [3:0]  io_switches,
  output logic [2:0]  io_reg_switches,
  input  logic [15:0] sw_addr,
  input  logic [15:0] sw_ctrl_n,
  input  logic [2:0]  sw_reg,
  output logic [15:0] addr_leds,
  output logic [15:0] data_leds,
  output logic        frame_done,
  output logic        link_ok
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned ToW = $clog2(LINK_TIMEOUT + 1);
  localparam logic [DbW-1:0] DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ToW-1:0] ToLimit = ToW'(LINK_TIMEOUT);
  // Switch vector layout: {sw_reg, sw_ctrl_n, sw_addr}
  localparam logic [34:0] SwRst = {3'b000, 16'hFFFF, 16'h0000};

  typedef enum logic [0:0] {StHunt, StRecv} state_e;

  // ---------------------------------------------------------------------------
  // Link input synchronisers
  // ---------------------------------------------------------------------------
  logic       io_clk_s1_q, io_clk_s2_q, io_clk_prev_q;
  logic [2:0] io_addr_s1_q, io_addr_s2_q;
  logic [3:0] io_leds_s1_q, io_leds_s2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io_clk_s1_q   <= 1'b0;
      io_clk_s2_q   <= 1'b0;
      io_clk_prev_q <= 1'b0;
      io_addr_s1_q  <= 3'd0;
      io_addr_s2_q  <= 3'd0;
      io_leds_s1_q  <= 4'd0;
      io_leds_s2_q  <= 4'd0;
    end else begin
      io_clk_s1_q   <= io_clk;
      io_clk_s2_q   <= io_clk_s1_q;
      io_clk_prev_q <= io_clk_s2_q;
      io_addr_s1_q  <= io_addr;
      io_addr_s2_q  <= io_addr_s1_q;
      io_leds_s1_q  <= io_leds;
      io_leds_s2_q  <= io_leds_s1_q;
    end
  end

  logic       fe;
  logic [2:0] idx;

  assign fe  = io_clk_prev_q & ~io_clk_s2_q;
  // io_leds carries the nibble for the previous address
  assign idx = io_addr_s2_q - 3'd1;

  // ---------------------------------------------------------------------------
  // Frame capture and commit
  // ---------------------------------------------------------------------------
  state_e         state_q, state_d;
  logic [2:0]     exp_idx_q, exp_idx_d;
  logic           valid_q, valid_d;
  logic [15:0]    addr_shadow_q, addr_shadow_d;
  logic [15:0]    data_shadow_q, data_shadow_d;
  logic [15:0]    addr_leds_q, addr_leds_d;
  logic [15:0]    data_leds_q, data_leds_d;
  logic           frame_done_q, frame_done_d;
  logic           link_ok_q, link_ok_d;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           seq_err;
  logic           timed_out;

  assign seq_err   = (idx != exp_idx_q);
  assign timed_out = (to_cnt_q == ToLimit);

  always_comb begin
    state_d       = state_q;
    exp_idx_d     = exp_idx_q;
    valid_d       = valid_q;
    addr_shadow_d = addr_shadow_q;
    data_shadow_d = data_shadow_q;
    addr_leds_d   = addr_leds_q;
    data_leds_d   = data_leds_q;
    frame_done_d  = 1'b0;
    link_ok_d     = link_ok_q;
    to_cnt_d      = to_cnt_q;

    if (fe) begin
      // A falling edge always wins over a coincident timeout expiry
      to_cnt_d  = '0;
      exp_idx_d = idx + 3'd1;
      if (!idx[2]) begin
        addr_shadow_d[{idx[1:0], 2'b00} +: 4] = io_leds_s2_q;
      end else begin
        data_shadow_d[{idx[1:0], 2'b00} +: 4] = io_leds_s2_q;
      end

      unique case (state_q)
        StHunt: begin
          if (idx == 3'd0) begin
            state_d = StRecv;
            valid_d = 1'b1;
          end
        end
        StRecv: begin
          if (seq_err) begin
            state_d   = StHunt;
            valid_d   = 1'b0;
            link_ok_d = 1'b0;
          end else if (idx == 3'd7 && valid_q) begin
            addr_leds_d  = addr_shadow_d;
            data_leds_d  = data_shadow_d;
            frame_done_d = 1'b1;
            link_ok_d    = 1'b1;
            valid_d      = 1'b1;
          end
        end
        default: state_d = StHunt;
      endcase
    end else if (timed_out) begin
      state_d   = StHunt;
      valid_d   = 1'b0;
      link_ok_d = 1'b0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StHunt;
      exp_idx_q     <= 3'd0;
      valid_q       <= 1'b0;
      addr_shadow_q <= 16'h0000;
      data_shadow_q <= 16'h0000;
      addr_leds_q   <= 16'h0000;
      data_leds_q   <= 16'h0000;
      frame_done_q  <= 1'b0;
      link_ok_q     <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      exp_idx_q     <= exp_idx_d;
      valid_q       <= valid_d;
      addr_shadow_q <= addr_shadow_d;
      data_shadow_q <= data_shadow_d;
      addr_leds_q   <= addr_leds_d;
      data_leds_q   <= data_leds_d;
      frame_done_q  <= frame_done_d;
      link_ok_q     <= link_ok_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign addr_leds  = addr_leds_q;
  assign data_leds  = data_leds_q;
  assign frame_done = frame_done_q;
  assign link_ok    = link_ok_q;

  // ---------------------------------------------------------------------------
  // Switch debounce and serving
  // ---------------------------------------------------------------------------
  logic [DbW-1:0] tick_cnt_q, tick_cnt_d;
  logic           tick;
  logic [34:0]    sw_raw;
  logic [34:0]    sample_q, sample_d;
  logic [34:0]    deb_q, deb_d;
  logic [34:0]    sw_diff;
  logic [31:0]    serve_vec;
  logic [3:0]     io_switches_q, io_switches_d;
  logic [2:0]     io_reg_switches_q, io_reg_switches_d;

  assign tick    = (tick_cnt_q == DbLast);
  assign sw_raw  = {sw_reg, sw_ctrl_n, sw_addr};
  assign sw_diff = sw_raw ^ sample_q;

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    sample_d   = sample_q;
    deb_d      = deb_q;
    if (tick) begin
      sample_d = sw_raw;
      // Per bit: accept the new value only if it matches the previous sample
      deb_d    = (deb_q & sw_diff) | (sw_raw & ~sw_diff);
    end
  end

  assign serve_vec         = deb_q[31:0];
  assign io_switches_d     = serve_vec[{io_addr_s2_q, 2'b00} +: 4];
  assign io_reg_switches_d = deb_q[34:32];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q        <= '0;
      sample_q          <= SwRst;
      deb_q             <= SwRst;
      io_switches_q     <= 4'h0;
      io_reg_switches_q <= 3'd0;
    end else begin
      tick_cnt_q        <= tick_cnt_d;
      sample_q          <= sample_d;
      deb_q             <= deb_d;
      io_switches_q     <= io_switches_d;
      io_reg_switches_q <= io_reg_switches_d;
    end
  end

  assign io_switches     = io_switches_q;
  assign io_reg_switches = io_reg_switches_q;

endmodule

// File: tb/tb_k16_panel_mux.sv
// Directed bench for k16_panel_mux: frame assembly, tear-free commit, sequence error,
// timeout, switch serving, debounce and asynchronous reset mid-frame.
module tb_k16_panel_mux;

  localparam int unsigned DB = 8;
  localparam int unsigned TO = 300;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        io_clk;
  logic [2:0]  io_addr;
  logic [3:0]  io_leds;
  logic [3:0]  io_switches;
  logic [2:0]  io_reg_switches;
  logic [15:0] sw_addr;
  logic [15:0] sw_ctrl_n;
  logic [2:0]  sw_reg;
  logic [15:0] addr_leds;
  logic [15:0] data_leds;
  logic        frame_done;
  logic        link_ok;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int fd0;

  logic [3:0] sw_exp [8];

  k16_panel_mux #(
    .DEBOUNCE_CYCLES(DB),
    .LINK_TIMEOUT   (TO)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .io_clk         (io_clk),
    .io_addr        (io_addr),
    .io_leds        (io_leds),
    .io_switches    (io_switches),
    .io_reg_switches(io_reg_switches),
    .sw_addr        (sw_addr),
    .sw_ctrl_n      (sw_ctrl_n),
    .sw_reg         (sw_reg),
    .addr_leds      (addr_leds),
    .data_leds      (data_leds),
    .frame_done     (frame_done),
    .link_ok        (link_ok)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_nib(input int idx, input logic [3:0] nib);
    io_addr = 3'(idx + 1);
    io_leds = nib;
    io_clk  = 1'b1;
    clocks(10);
    io_clk  = 1'b0;
    clocks(10);
  endtask

  function automatic logic [3:0] nib_of(input logic [15:0] a, input logic [15:0] d, input int i);
    logic [31:0] v;
    v = {d, a};
    return v[i*4 +: 4];
  endfunction

  task automatic send_frame(input logic [15:0] a, input logic [15:0] d);
    for (int i = 0; i < 8; i++) send_nib(i, nib_of(a, d, i));
  endtask

  initial begin
    sw_exp = '{4'h3, 4'hC, 4'h5, 4'hA, 4'hB, 4'hF, 4'hF, 4'hF};
    reset_n   = 1'b0;
    io_clk    = 1'b0;
    io_addr   = 3'd0;
    io_leds   = 4'h0;
    sw_addr   = 16'h0000;
    sw_ctrl_n = 16'hFFFF;
    sw_reg    = 3'd0;
    clocks(3);
    check("rst_addr_leds", 32'(addr_leds), 32'h0);
    check("rst_data_leds", 32'(data_leds), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_link_ok", 32'(link_ok), 32'h0);
    check("rst_io_switches", 32'(io_switches), 32'h0);
    check("rst_reg_switches", 32'(io_reg_switches), 32'h0);
    reset_n = 1'b1;
    clocks(2);

    // Full frame; LEDs must not move before idx 7
    fd0 = fd_cnt;
    for (int i = 0; i < 7; i++) send_nib(i, nib_of(16'hBEEF, 16'h1234, i));
    check("tear_mid_frame", 32'(addr_leds), 32'h0);
    send_nib(7, nib_of(16'hBEEF, 16'h1234, 7));
    check("frame_addr", 32'(addr_leds), 32'hBEEF);
    check("frame_data", 32'(data_leds), 32'h1234);
    check("frame_link_ok", 32'(link_ok), 32'h1);
    check("frame_done_cnt", 32'(fd_cnt - fd0), 32'h1);

    // Commit zeros, then a partial frame followed by a stall
    send_frame(16'h0000, 16'h0000);
    check("zero_addr", 32'(addr_leds), 32'h0);
    check("zero_data", 32'(data_leds), 32'h0);
    for (int i = 0; i < 6; i++) send_nib(i, 4'h9);
    clocks(TO + 50);
    check("stall_addr", 32'(addr_leds), 32'h0);
    check("stall_data", 32'(data_leds), 32'h0);
    check("stall_link_ok", 32'(link_ok), 32'h0);

    send_frame(16'hCAFE, 16'h5A5A);
    check("recover_addr", 32'(addr_leds), 32'hCAFE);
    check("recover_link_ok", 32'(link_ok), 32'h1);

    // Sequence error: idx 3 skipped
    fd0 = fd_cnt;
    send_nib(0, 4'h7);
    send_nib(1, 4'h7);
    send_nib(2, 4'h7);
    send_nib(4, 4'h7);
    check("seqerr_link_ok", 32'(link_ok), 32'h0);
    send_nib(5, 4'h7);
    send_nib(6, 4'h7);
    send_nib(7, 4'h7);
    check("seqerr_addr", 32'(addr_leds), 32'hCAFE);
    check("seqerr_data", 32'(data_leds), 32'h5A5A);
    check("seqerr_no_done", 32'(fd_cnt - fd0), 32'h0);
    send_frame(16'h1357, 16'h2468);
    check("after_err_addr", 32'(addr_leds), 32'h1357);
    check("after_err_data", 32'(data_leds), 32'h2468);
    check("after_err_link", 32'(link_ok), 32'h1);

    // Switch serving, 3-clk latency from io_addr
    sw_addr   = 16'hA5C3;
    sw_ctrl_n = 16'hFFFB;
    sw_reg    = 3'd5;
    clocks(3 * DB + 4);
    for (int a = 0; a < 8; a++) begin
      io_addr = 3'(a);
      clocks(3);
      check($sformatf("serve_addr%0d", a), 32'(io_switches), 32'(sw_exp[a]));
    end
    check("reg_switches", 32'(io_reg_switches), 32'h5);

    // Debounce: bounce, then stable, then a one-tick glitch
    io_addr = 3'd0;
    sw_addr = 16'hA5C2;
    clocks(3 * DB + 4);
    check("db_base", 32'(io_switches), 32'h2);
    for (int i = 0; i < 4; i++) begin
      sw_addr[0] = (i % 2 == 0);
      clocks(1);
    end
    sw_addr[0] = 1'b1;
    check("db_bounce_hold", 32'(io_switches), 32'h2);
    clocks(2 * DB + 4);
    check("db_accept", 32'(io_switches), 32'h3);
    sw_addr[0] = 1'b0;
    clocks(DB);
    sw_addr[0] = 1'b1;
    check("db_glitch_during", 32'(io_switches), 32'h3);
    clocks(2 * DB);
    check("db_glitch_after", 32'(io_switches), 32'h3);

    // Asynchronous reset mid-frame
    send_frame(16'h4321, 16'h8765);
    check("pre_rst_addr", 32'(addr_leds), 32'h4321);
    for (int i = 0; i < 5; i++) send_nib(i, 4'hD);
    reset_n = 1'b0;
    #1;
    check("midrst_addr", 32'(addr_leds), 32'h0);
    check("midrst_data", 32'(data_leds), 32'h0);
    check("midrst_link_ok", 32'(link_ok), 32'h0);
    check("midrst_io_switches", 32'(io_switches), 32'h0);
    check("midrst_reg_sw", 32'(io_reg_switches), 32'h0);
    clocks(2);
    reset_n = 1'b1;
    io_addr = 3'd4;
    clocks(3);
    check("midrst_ctrl_nibble", 32'(io_switches), 32'hF);
    fd0 = fd_cnt;
    send_nib(5, 4'hD);
    send_nib(6, 4'hD);
    send_nib(7, 4'hD);
    check("midrst_tail_addr", 32'(addr_leds), 32'h0);
    check("midrst_tail_done", 32'(fd_cnt - fd0), 32'h0);
    send_frame(16'hABCD, 16'hEF01);
    check("midrst_commit_addr", 32'(addr_leds), 32'hABCD);
    check("midrst_commit_data", 32'(data_leds), 32'hEF01);
    check("midrst_commit_done", 32'(fd_cnt - fd0), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/k16_panel_mux.md
Name: k16_panel_mux

Overview:
- Panel-side end of the K16 front-panel serial nibble link.
- The CPU-side I/O block drives io_clk (about 50 Hz), a 3-bit nibble address io_addr and a 4-bit LED nibble io_leds. It samples a 4-bit switch nibble, io_switches, together with 3 register-select lines.
- This block runs on the panel board's own clock. It reassembles the nibbles into the 16-bit address LED and 16-bit data LED banks, with tear-free frame commit.
- It also debounces the physical address, control and register switches and serves the matching nibble back for each io_addr.

Parameters:
- DEBOUNCE_CYCLES, 250000: clk cycles between switch samples (10 ms at 25 MHz).
- LINK_TIMEOUT, 2500000: clk cycles without an io_clk falling edge before link_ok drops (100 ms).

Ports:
- clk  in  1: panel clock, rising edge.
- reset_n  in  1: asynchronous active-low reset.
- io_clk  in  1: link clock from the CPU side, asynchronous to clk.
- io_addr  in  3: current nibble address; changes on io_clk rising edge.
- io_leds  in  4: LED nibble for index (io_addr-1) mod 8; valid after io_clk rising edge.
- io_switches  out  4: switch nibble for the current io_addr.
- io_reg_switches  out  3: debounced register-select switches.
- sw_addr  in  16: raw address toggles, active-high.
- sw_ctrl_n  in  16: raw control pushbuttons, active-low (1 = released).
- sw_reg  in  3: raw register-select toggles.
- addr_leds  out  16: committed address LED bank.
- data_leds  out  16: committed data LED bank.
- frame_done  out  1: one-clk pulse when a full 8-nibble frame commits.
- link_ok  out  1: a valid in-sequence frame has been received and there is no timeout.

Behaviour:
- Synchronisation: io_clk, io_addr and io_leds each pass through 2-flop synchronisers into clk. An io_clk falling edge (fe) is detected on the synchronised io_clk (prev=1, now=0).
- Capture:
  - On fe, idx = (io_addr_s - 1) mod 8. Write io_leds_s into shadow nibble idx: idx 0..3 → addr shadow [3:0]..[15:12]; idx 4..7 → data shadow [3:0]..[15:12].
  - expected_idx register, reset 0. If idx == expected_idx, then expected_idx <= idx+1 (wraps 7→0).
  - On mismatch (sequence error): set expected_idx <= idx+1, mark frame invalid, clear link_ok. The shadow nibble is still written.
- Frame state machine:
  - States: HUNT (reset) waits for fe with idx==0 → RECV.
  - RECV: each in-sequence fe is accepted. When idx==7 is accepted and the frame is valid, addr_leds/data_leds <= shadow in the same clk, frame_done pulses 1 clk, link_ok <= 1, and the FSM stays in RECV with the valid flag re-armed.
  - A sequence error or timeout returns the FSM to HUNT.
  - Frames are never partially committed.
- Timeout: a counter of clk cycles since the last fe, saturating at LINK_TIMEOUT. On reaching it: link_ok <= 0, FSM → HUNT, and the LED outputs hold their last committed value.
- Debounce:
  - A shared tick counter pulses every DEBOUNCE_CYCLES.
  - On each tick, every one of the 35 raw inputs is sampled into a sample1 register.
  - The debounced value is updated only when the new sample equals the previous sample, i.e. the input was stable for 2 consecutive ticks. Worst-case acceptance latency is 2×DEBOUNCE_CYCLES + 2 clk.
- Switch serving (registered, every clk, from io_addr_s):
  - 0..3 → debounced sw_addr nibbles [3:0]..[15:12].
  - 4..7 → debounced sw_ctrl_n nibbles [3:0]..[15:12], passed active-low unchanged.
  - Latency from an io_addr pin change is 3 clk, well inside half an io_clk period.
  - io_reg_switches = debounced sw_reg, registered.
- Reset values (async, reset_n=0):
  - addr_leds = data_leds = shadow = 0.
  - frame_done = 0, link_ok = 0, FSM = HUNT, expected_idx = 0.
  - Debounced sw_addr = 0, sw_ctrl_n = 16'hFFFF, sw_reg = 0.
  - io_switches = 4'h0 for io_addr_s = 0 (the synchroniser resets to 0).
  - Timeout and tick counters = 0.
- Reset mid-frame: the partial frame is discarded and re-acquisition starts at the next idx==0.
- Simultaneous events: if a debounce tick coincides with fe, both are processed in that clk. If a timeout expiry coincides with fe, the fe wins: the counter clears and the capture proceeds.

Test Plan:
- Full frame: drive 8 nibbles for addr=16'hBEEF and data=16'h1234 at io_clk=50 Hz equivalent. Expect addr_leds=BEEF, data_leds=1234, one frame_done pulse after idx 7, and link_ok=1.
- Tear-free commit: after committing 0000/0000, send idx 0..5 of a new frame, then stall io_clk beyond LINK_TIMEOUT. Expect outputs still 0000/0000 and link_ok=0.
- Sequence error: skip idx 3 (jump from 2 to 4). Expect no commit for that frame, FSM back to HUNT, and the next complete 0..7 frame commits.
- Switch serving: set debounced sw_addr=16'hA5C3 and sw_ctrl_n=16'hFFFB (bit2 pressed), then step io_addr 0..7. Expect io_switches 3,C,5,A,B,F,F,F respectively.
- Debounce: toggle sw_addr[0] 0→1 and bounce it for 0.5×DEBOUNCE_CYCLES. Expect no change until two consecutive stable ticks, then io_switches[0]=1 when io_addr=0. A single-tick glitch is rejected.
- Async reset mid-frame: assert reset_n=0 at idx 4. Expect all outputs at reset values immediately, with io_switches nibble 4..7 reading F. After release, the first commit occurs only after a complete 0..7 frame.
